saes_mix_key_stage: RTL

- Registered S-AES encryption round stage, directly downstream of the nibble-substitution stage.
- Consumes the 16-bit nibble-substituted state and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Result is held in a 2-entry elastic output buffer with valid/ready handshakes on both sides, so the round loop can stall without losing data.

---
 rtl/saes_mix_key_stage_if.sv | 23 ++
 rtl/saes_mix_key_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/saes_mix_key_stage_if.sv
// Handshake bundle for the S-AES ShiftRows/MixColumns/AddRoundKey stage.
// The master drives the upstream block and the downstream ready; the stage is the slave.
interface saes_mix_key_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_state;
  logic [15:0] round_key;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_state;
  logic        out_last;

  modport master (
    output in_valid, in_state, round_key, in_last, out_ready,
    input  in_ready, out_valid, out_state, out_last
  );

  modport slave (
    input  in_valid, in_state, round_key, in_last, out_ready,
    output in_ready, out_valid, out_state, out_last
  );
endinterface

// File: rtl/saes_mix_key_stage.sv
// S-AES round stage: ShiftRows, MixColumns (skipped on last round), AddRoundKey, 2-entry FIFO.
// Define SAES_MIX_STATS_EN to add the blk_count / stall_count statistics ports.
module saes_mix_key_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SAES_MIX_STATS_EN
  output logic [15:0]          blk_count,
  output logic [15:0]          stall_count,
`endif
  saes_mix_key_stage_if.slave  bus
);

  if (DEPTH != 2) begin : g_depth_check
    $error("saes_mix_key_stage: only DEPTH == 2 is supported");
  end

  function automatic logic [3:0] m2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] m4(input logic [3:0] x);
    return m2(m2(x));
  endfunction

  logic [15:0] sr_state;
  logic [15:0] mc_state;
  logic [15:0] mix_result;

  always_comb begin
    sr_state   = {bus.in_state[15:12], bus.in_state[3:0], bus.in_state[7:4], bus.in_state[11:8]};
    mc_state   = {sr_state[15:12] ^ m4(sr_state[11:8]), m4(sr_state[15:12]) ^ sr_state[11:8],
                  sr_state[7:4]   ^ m4(sr_state[3:0]),  m4(sr_state[7:4])   ^ sr_state[3:0]};
    mix_result = (bus.in_last ? sr_state : mc_state) ^ bus.round_key;
  end

  // Each entry is {last, state}.
  logic [16:0] mem_q [2];
  logic [16:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] out_state_q, out_state_d;
  logic        out_last_q, out_last_d;
  logic        in_ready;
  logic        out_valid;
  logic        push;
  logic        pop;

  always_comb begin
    in_ready  = (count_q < 2'd2);
    out_valid = (count_q != 2'd0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_last, mix_result};
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Registered head; when the buffer drains the last shown block is held.
    if (count_d != 2'd0) begin
      {out_last_d, out_state_d} = mem_d[rd_ptr_d];
    end else begin
      out_last_d  = out_last_q;
      out_state_d = out_state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      out_state_q <= 16'h0000;
      out_last_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_state_q <= out_state_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_state = out_state_q;
  assign bus.out_last  = out_last_q;

`ifdef SAES_MIX_STATS_EN
  logic [15:0] blk_count_q, blk_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    blk_count_d   = blk_count_q + (pop ? 16'd1 : 16'd0);
    stall_count_d = stall_count_q;
    if (out_valid && !bus.out_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_count_q   <= 16'h0000;
      stall_count_q <= 16'h0000;
    end else begin
      blk_count_q   <= blk_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign blk_count   = blk_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
